// File: rtl/swipe_gesture_fsm.sv
// swipe_gesture_fsm
//
// Per-frame gesture stage. Samples the dominant-motion zone once per frame at
// a fixed raster position, debounces it with a consecutive-frame persistence
// filter and runs a swipe state machine that pulses when the stable zone
// sweeps from one edge of the frame to the other.
//
// Ports:
//   iCLK        pixel clock
//   iRST        asynchronous active-high reset
//   iH_Cont     horizontal raster counter
//   iV_Cont     vertical raster counter
//   iDirection  raw zone 0..6, 7 = no motion (valid at the sample point)
//   oStableDir  debounced zone (reset 7)
//   oDirChange  one-cycle pulse when oStableDir changes
//   oSwipeInc   one-cycle pulse on a 0/1 -> 5/6 sweep
//   oSwipeDec   one-cycle pulse on a 5/6 -> 0/1 sweep
//   oState      FSM state: 0 idle, 1 armed inc, 2 armed dec, 3 cooldown
module swipe_gesture_fsm #(
  parameter int unsigned SAMPLE_H    = 1016,
  parameter int unsigned SAMPLE_V    = 626,
  parameter int unsigned HOLD_FRAMES = 3,
  parameter int unsigned SWIPE_WIN   = 30,
  parameter int unsigned COOL_FRAMES = 15
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [12:0] iH_Cont,
  input  logic [12:0] iV_Cont,
  input  logic [2:0]  iDirection,
  output logic [2:0]  oStableDir,
  output logic        oDirChange,
  output logic        oSwipeInc,
  output logic        oSwipeDec,
  output logic [1:0]  oState
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StArmInc = 2'd1,
    StArmDec = 2'd2,
    StCool   = 2'd3
  } state_e;

  // Sample strobes: s1 filters, s2 (one clock later) steps the FSM so it sees
  // the freshly updated stable zone.
  logic       s1;
  logic       s2_q;

  logic [2:0] last_raw_q;
  logic [3:0] run_q;
  logic [3:0] run_next;
  logic [2:0] stable_q;
  logic       dir_change_q;
  logic       take_new;

  state_e     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [6:0] cnt_inc;
  logic       inc_q, inc_d;
  logic       dec_q, dec_d;
  logic       zone_lo, zone_hi;

  assign s1 = (iH_Cont == 13'(SAMPLE_H)) && (iV_Cont == 13'(SAMPLE_V));

  // Persistence filter
  always_comb begin
    run_next = 4'd1;
    if (iDirection == last_raw_q) begin
      run_next = (run_q == 4'd15) ? 4'd15 : run_q + 4'd1;
    end
    take_new = (32'(run_next) >= HOLD_FRAMES) && (iDirection != stable_q);
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      s2_q         <= 1'b0;
      last_raw_q   <= 3'd7;
      run_q        <= 4'd0;
      stable_q     <= 3'd7;
      dir_change_q <= 1'b0;
    end else begin
      s2_q         <= s1;
      dir_change_q <= 1'b0;
      if (s1) begin
        last_raw_q <= iDirection;
        run_q      <= run_next;
        if (take_new) begin
          stable_q     <= iDirection;
          dir_change_q <= 1'b1;
        end
      end
    end
  end

  // Swipe FSM
  assign zone_lo = (stable_q == 3'd0) || (stable_q == 3'd1);
  assign zone_hi = (stable_q == 3'd5) || (stable_q == 3'd6);
  assign cnt_inc = {1'b0, cnt_q} + 7'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    inc_d   = 1'b0;
    dec_d   = 1'b0;
    if (s2_q) begin
      unique case (state_q)
        StIdle: begin
          if (zone_lo) begin
            state_d = StArmInc;
            cnt_d   = 6'd0;
          end else if (zone_hi) begin
            state_d = StArmDec;
            cnt_d   = 6'd0;
          end
        end
        StArmInc: begin
          // Completion is checked first so it wins over the window expiring.
          if (zone_hi) begin
            inc_d   = 1'b1;
            state_d = StCool;
            cnt_d   = 6'd0;
          end else if (32'(cnt_inc) >= SWIPE_WIN) begin
            state_d = StIdle;
            cnt_d   = 6'd0;
          end else begin
            cnt_d = cnt_inc[5:0];
          end
        end
        StArmDec: begin
          if (zone_lo) begin
            dec_d   = 1'b1;
            state_d = StCool;
            cnt_d   = 6'd0;
          end else if (32'(cnt_inc) >= SWIPE_WIN) begin
            state_d = StIdle;
            cnt_d   = 6'd0;
          end else begin
            cnt_d = cnt_inc[5:0];
          end
        end
        StCool: begin
          if (32'(cnt_inc) >= COOL_FRAMES) begin
            state_d = StIdle;
            cnt_d   = 6'd0;
          end else begin
            cnt_d = cnt_inc[5:0];
          end
        end
      endcase
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q <= StIdle;
      cnt_q   <= 6'd0;
      inc_q   <= 1'b0;
      dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      inc_q   <= inc_d;
      dec_q   <= dec_d;
    end
  end

  assign oStableDir = stable_q;
  assign oDirChange = dir_change_q;
  assign oSwipeInc  = inc_q;
  assign oSwipeDec  = dec_q;
  assign oState     = state_q;

endmodule

// File: tb/tb_swipe_gesture_fsm.sv
// Testbench for swipe_gesture_fsm: table-driven frame vectors plus directed
// sequences for window timeout, window boundary, mid-frame reset and
// non-matching raster counters.
module tb_swipe_gesture_fsm;

  localparam int unsigned SH = 1016;
  localparam int unsigned SV = 626;

  logic        clk;
  logic        rst;
  logic [12:0] h_cnt;
  logic [12:0] v_cnt;
  logic [2:0]  dir;
  logic [2:0]  stable;
  logic        dchg;
  logic        sinc;
  logic        sdec;
  logic [1:0]  state;

  swipe_gesture_fsm #(
    .SAMPLE_H   (SH),
    .SAMPLE_V   (SV),
    .HOLD_FRAMES(3),
    .SWIPE_WIN  (30),
    .COOL_FRAMES(15)
  ) dut (
    .iCLK      (clk),
    .iRST      (rst),
    .iH_Cont   (h_cnt),
    .iV_Cont   (v_cnt),
    .iDirection(dir),
    .oStableDir(stable),
    .oDirChange(dchg),
    .oSwipeInc (sinc),
    .oSwipeDec (sdec),
    .oState    (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] dir;
    logic [2:0] st;
    logic       dc;
    logic       inc;
    logic       dec;
    logic [1:0] state;
  } vec_t;

  // Observations around one sample strobe: suffix 1 = S1+1, 2 = S1+2, 3 = S1+3.
  typedef struct {
    logic [2:0] st1;
    logic       dc1, inc1, dec1;
    logic       dc2, inc2, dec2;
    logic [1:0] state2;
    logic       inc3, dec3;
  } obs_t;

  vec_t vecs[$];
  int   n_vec;
  int   n_miss;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic [2:0] d, input logic [2:0] st, input logic dc,
                     input logic inc, input logic dec, input logic [1:0] s);
    vec_t v;
    v.dir = d; v.st = st; v.dc = dc; v.inc = inc; v.dec = dec; v.state = s;
    vecs.push_back(v);
  endtask

  task automatic frame(input logic [2:0] d, output obs_t o);
    @(negedge clk);
    dir = d; h_cnt = 13'd0; v_cnt = 13'd0;
    @(negedge clk);
    h_cnt = 13'(SH); v_cnt = 13'(SV);
    @(negedge clk);
    h_cnt = 13'd0; v_cnt = 13'd0;
    o.st1 = stable; o.dc1 = dchg; o.inc1 = sinc; o.dec1 = sdec;
    @(negedge clk);
    o.dc2 = dchg; o.inc2 = sinc; o.dec2 = sdec; o.state2 = state;
    @(negedge clk);
    o.inc3 = sinc; o.dec3 = sdec;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    obs_t o;
    logic saw;
    n_vec  = 0;
    n_miss = 0;
    rst    = 1'b1;
    h_cnt  = 13'd0;
    v_cnt  = 13'd0;
    dir    = 3'd7;

    // Debounce, increasing swipe, cooldown, decreasing swipe.
    add(3, 7, 0, 0, 0, 0);
    add(3, 7, 0, 0, 0, 0);
    add(2, 7, 0, 0, 0, 0);
    add(3, 7, 0, 0, 0, 0);
    add(3, 7, 0, 0, 0, 0);
    add(3, 3, 1, 0, 0, 0);
    add(0, 3, 0, 0, 0, 0);
    add(0, 3, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 1);
    add(3, 0, 0, 0, 0, 1);
    add(3, 0, 0, 0, 0, 1);
    add(3, 3, 1, 0, 0, 1);
    add(3, 3, 0, 0, 0, 1);
    add(3, 3, 0, 0, 0, 1);
    add(6, 3, 0, 0, 0, 1);
    add(6, 3, 0, 0, 0, 1);
    add(6, 6, 1, 1, 0, 3);
    add(0, 6, 0, 0, 0, 3);
    add(0, 6, 0, 0, 0, 3);
    add(0, 0, 1, 0, 0, 3);
    add(6, 0, 0, 0, 0, 3);
    add(6, 0, 0, 0, 0, 3);
    add(6, 6, 1, 0, 0, 3);
    for (int i = 0; i < 8; i++) add(6, 6, 0, 0, 0, 3);
    add(6, 6, 0, 0, 0, 0);
    add(6, 6, 0, 0, 0, 2);
    add(0, 6, 0, 0, 0, 2);
    add(0, 6, 0, 0, 0, 2);
    add(0, 0, 1, 0, 1, 3);

    repeat (2) @(negedge clk);
    chk("reset_stable", int'(stable), 7);
    chk("reset_state", int'(state), 0);
    chk("reset_pulses", int'({dchg, sinc, sdec}), 0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      frame(vecs[i].dir, o);
      chk($sformatf("v%0d_stable", i), int'(o.st1), int'(vecs[i].st));
      chk($sformatf("v%0d_dirchg", i), int'(o.dc1), int'(vecs[i].dc));
      chk($sformatf("v%0d_dirchg_len", i), int'(o.dc2), 0);
      chk($sformatf("v%0d_early_pulse", i), int'({o.inc1, o.dec1}), 0);
      chk($sformatf("v%0d_inc", i), int'(o.inc2), int'(vecs[i].inc));
      chk($sformatf("v%0d_dec", i), int'(o.dec2), int'(vecs[i].dec));
      chk($sformatf("v%0d_state", i), int'(o.state2), int'(vecs[i].state));
      chk($sformatf("v%0d_pulse_len", i), int'({o.inc3, o.dec3}), 0);
    end

    // Window timeout: arm on zone 6, then park in zone 3.
    do_reset();
    repeat (3) frame(3'd6, o);
    chk("to_armed", int'(o.state2), 2);
    saw = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      frame(3'd3, o);
      saw = saw | o.dec1 | o.dec2 | o.dec3 | o.inc2;
      if (k == 29) chk("to_state_29", int'(o.state2), 2);
      if (k == 30) chk("to_state_30", int'(o.state2), 0);
    end
    chk("to_no_pulse", int'(saw), 0);

    // Target zone reached exactly on the last strobe of the window.
    do_reset();
    repeat (3) frame(3'd0, o);
    chk("bd_armed", int'(o.state2), 1);
    for (int k = 1; k <= 30; k++) begin
      frame((k <= 27) ? 3'd3 : 3'd6, o);
      if (k == 29) chk("bd_state_29", int'(o.state2), 1);
      if (k == 30) begin
        chk("bd_inc", int'(o.inc2), 1);
        chk("bd_state_30", int'(o.state2), 3);
      end
    end

    // Asynchronous reset mid-frame while armed, with oDirChange high.
    do_reset();
    repeat (3) frame(3'd0, o);
    frame(3'd3, o);
    frame(3'd3, o);
    @(negedge clk);
    dir = 3'd3;
    @(negedge clk);
    h_cnt = 13'(SH); v_cnt = 13'(SV);
    @(negedge clk);
    h_cnt = 13'd0; v_cnt = 13'd0;
    chk("rst_pre_dc", int'(dchg), 1);
    chk("rst_pre_state", int'(state), 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_stable", int'(stable), 7);
    chk("rst_state", int'(state), 0);
    chk("rst_pulses", int'({dchg, sinc, sdec}), 0);
    @(negedge clk);
    rst = 1'b0;
    saw = 1'b0;
    for (int k = 0; k < 3; k++) begin
      frame(3'd6, o);
      saw = saw | o.inc1 | o.inc2 | o.inc3 | o.dec2 | o.dec3;
    end
    chk("rst_no_pulse", int'(saw), 0);
    chk("rst_rearm_dec", int'(o.state2), 2);

    // Counters matching on only one axis must not strobe.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      dir = 3'd0;
      h_cnt = (k % 2 == 0) ? 13'(SH) : 13'(SH - 1);
      v_cnt = (k % 2 == 0) ? 13'(SV - 1) : 13'(SV);
    end
    @(negedge clk);
    h_cnt = 13'd0; v_cnt = 13'd0;
    @(negedge clk);
    chk("nomatch_stable", int'(stable), 7);
    chk("nomatch_state", int'(state), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
